// File: rtl/seg7_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared state encoding and 7-segment code constants for the
//             multiplexed display controller.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   // Segment bit positions inside the 7-bit code: {a,b,c,d,e,f,g}
   localparam int SEG_A_BIT = 6;
   localparam int SEG_B_BIT = 5;
   localparam int SEG_C_BIT = 4;
   localparam int SEG_D_BIT = 3;
   localparam int SEG_E_BIT = 2;
   localparam int SEG_F_BIT = 1;
   localparam int SEG_G_BIT = 0;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [6:0] bcd_decode(input logic [3:0] bcd);
      logic [6:0] code;
      case (bcd)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg7
//  Brief    : Combinational BCD to 7-segment decoder; codes 10..15 are blank.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = bcd_decode(bcd);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Brief    : Time-multiplexed 7-segment scan controller with blank gap,
//             per-slot BCD snapshot and leading-zero suppression.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SHOW_CYCLES  = 1000,
   parameter int BLANK_CYCLES = 2
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    lz_blank,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_show_last  = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_DIGITS - 1);

   state_t                  r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [CNT_W-1:0]        r_cnt;
   logic [3:0]              r_snapshot;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_an;
   logic                    r_frame_done;

   logic [3:0]              w_nibble;
   logic                    w_latch;
   logic [3:0]              w_snap_next;
   logic [6:0]              w_seg_dec;
   logic                    w_upper_zero;
   logic                    w_suppress;
   logic [NUM_DIGITS-1:0]   w_onehot;

   assign w_nibble    = digits[{r_idx, 2'b00} +: 4];
   assign w_latch     = (r_state == BLANK) && (r_cnt == c_blank_last);
   assign w_snap_next = w_latch ? w_nibble : r_snapshot;

   bcd_to_seg7 u_dec (
      .bcd (w_snap_next),
      .seg (w_seg_dec)
   );

   // Suppressed only if this digit and every more-significant digit is zero.
   always_comb begin
      w_upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((i >= int'(r_idx)) && (digits[4*i +: 4] != 4'd0)) begin
            w_upper_zero = 1'b0;
         end
      end
   end

   assign w_suppress = lz_blank && (r_idx != '0) && w_upper_zero;

   always_comb begin
      w_onehot        = '0;
      w_onehot[r_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= OFF;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_snapshot   <= '0;
         r_seg        <= '0;
         r_an         <= '0;
         r_frame_done <= 1'b0;
      end else if (!enable) begin
         r_state      <= OFF;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_seg        <= '0;
         r_an         <= '0;
         r_frame_done <= 1'b0;
      end else begin
         case (r_state)
            OFF: begin
               r_state      <= BLANK;
               r_idx        <= '0;
               r_cnt        <= '0;
               r_seg        <= '0;
               r_an         <= '0;
               r_frame_done <= 1'b0;
            end
            BLANK: begin
               r_frame_done <= 1'b0;
               if (w_latch) begin
                  r_snapshot <= w_nibble;
                  r_cnt      <= '0;
                  r_state    <= SHOW;
                  r_seg      <= w_suppress ? SEG_BLANK : w_seg_dec;
                  r_an       <= w_suppress ? '0 : w_onehot;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  r_seg <= '0;
                  r_an  <= '0;
               end
            end
            SHOW: begin
               if (r_cnt == c_show_last) begin
                  r_cnt        <= '0;
                  r_state      <= BLANK;
                  r_seg        <= '0;
                  r_an         <= '0;
                  r_frame_done <= (r_idx == c_idx_last);
                  r_idx        <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
               end else begin
                  r_cnt        <= r_cnt + 1'b1;
                  r_frame_done <= 1'b0;
               end
            end
            default: begin
               r_state      <= OFF;
               r_idx        <= '0;
               r_cnt        <= '0;
               r_seg        <= '0;
               r_an         <= '0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Brief    : Self-checking bench for seg7_scan_ctrl (4 digits, 4 show, 2 blank).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;

   localparam int ND    = 4;
   localparam int SC    = 4;
   localparam int BC    = 2;
   localparam int SLOT  = BC + SC;
   localparam int FRAME = ND * SLOT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        lz_blank;
   logic [15:0] digits;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .SHOW_CYCLES  (SC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .lz_blank   (lz_blank),
      .digits     (digits),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] dec_tab [16];

   // Reference model: position within the frame, -1 while dark/off.
   int         m_pos = -1;
   logic       m_fd  = 1'b0;
   logic [6:0] m_lseg = '0;
   logic [3:0] m_lan  = '0;

   typedef struct {
      logic [15:0]      dig;
      logic             lz;
      logic [3:0][6:0]  s;
      logic [3:0][3:0]  a;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos = -1;
      m_fd  = 1'b0;
   endtask

   task automatic model_step(input logic en, input logic lz, input logic [15:0] dig);
      int  k;
      logic sup;
      if (!en) begin
         m_pos = -1;
         m_fd  = 1'b0;
      end else if (m_pos < 0) begin
         m_pos = 0;
         m_fd  = 1'b0;
      end else begin
         m_fd  = (m_pos == FRAME - 1);
         m_pos = (m_pos + 1) % FRAME;
      end
      if (m_pos >= 0 && (m_pos % SLOT) == BC) begin
         k      = m_pos / SLOT;
         sup    = lz && (k != 0) && ((dig >> (4 * k)) == 16'd0);
         m_lseg = sup ? 7'd0 : dec_tab[dig[4*k +: 4]];
         m_lan  = sup ? 4'd0 : 4'(1 << k);
      end
   endtask

   function automatic logic [6:0] exp_seg();
      return (m_pos >= 0 && (m_pos % SLOT) >= BC) ? m_lseg : 7'd0;
   endfunction

   function automatic logic [3:0] exp_an();
      return (m_pos >= 0 && (m_pos % SLOT) >= BC) ? m_lan : 4'd0;
   endfunction

   task automatic tick(input logic en, input logic lz, input logic [15:0] dig);
      enable   = en;
      lz_blank = lz;
      digits   = dig;
      model_step(en, lz, dig);
      @(posedge clk);
      #1;
      check("model_seg", 32'(seg), 32'(exp_seg()));
      check("model_an", 32'(an), 32'(exp_an()));
      check("model_frame_done", 32'(frame_done), 32'(m_fd));
      check("an_onehot", 32'($countones(an) <= 1), 32'd1);
   endtask

   initial begin
      int          fd_cnt;
      logic [15:0] rdig;
      logic        ren, rlz;

      dec_tab[0] = 7'b1111110; dec_tab[1] = 7'b0110000; dec_tab[2] = 7'b1101101;
      dec_tab[3] = 7'b1111001; dec_tab[4] = 7'b0110011; dec_tab[5] = 7'b1011011;
      dec_tab[6] = 7'b1011111; dec_tab[7] = 7'b1110000; dec_tab[8] = 7'b1111111;
      dec_tab[9] = 7'b1111011;
      for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0000000;

      // Per-digit expectations, digit 3 first in each concatenation.
      vecs[0] = '{16'h1234, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011},
                  {4'b1000, 4'b0100, 4'b0010, 4'b0001}};
      vecs[1] = '{16'h0070, 1'b1, {7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110},
                  {4'b0000, 4'b0000, 4'b0010, 4'b0001}};
      vecs[2] = '{16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110},
                  {4'b0000, 4'b0000, 4'b0000, 4'b0001}};
      vecs[3] = '{16'h000A, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b0000000},
                  {4'b1000, 4'b0100, 4'b0010, 4'b0001}};
      vecs[4] = '{16'h9856, 1'b0, {7'b1111011, 7'b1111111, 7'b1011011, 7'b1011111},
                  {4'b1000, 4'b0100, 4'b0010, 4'b0001}};
      vecs[5] = '{16'h0105, 1'b1, {7'b0000000, 7'b0110000, 7'b1111110, 7'b1011011},
                  {4'b0000, 4'b0100, 4'b0010, 4'b0001}};
      vecs[6] = '{16'h0000, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110},
                  {4'b1000, 4'b0100, 4'b0010, 4'b0001}};

      // Reset held with enable high
      rst_n    = 1'b0;
      enable   = 1'b1;
      lz_blank = 1'b0;
      digits   = 16'h1234;
      model_reset();
      repeat (3) begin
         @(posedge clk);
         #1;
         check("reset_seg", 32'(seg), 32'd0);
         check("reset_an", 32'(an), 32'd0);
         check("reset_frame_done", 32'(frame_done), 32'd0);
      end
      rst_n = 1'b1;

      // Two frames of scanning: frame_done pulses once per frame
      fd_cnt = 0;
      for (int t = 0; t <= 2 * FRAME; t++) begin
         tick(1'b1, 1'b0, 16'h1234);
         if (frame_done) fd_cnt++;
      end
      check("frame_done_count", 32'(fd_cnt), 32'd2);

      // Table-driven frames
      for (int v = 0; v < 7; v++) begin
         tick(1'b0, vecs[v].lz, vecs[v].dig);
         for (int t = 0; t <= FRAME; t++) begin
            tick(1'b1, vecs[v].lz, vecs[v].dig);
            if ((t % SLOT) == BC + 1) begin
               check($sformatf("tbl%0d_seg_d%0d", v, t / SLOT), 32'(seg), 32'(vecs[v].s[t / SLOT]));
               check($sformatf("tbl%0d_an_d%0d", v, t / SLOT), 32'(an), 32'(vecs[v].a[t / SLOT]));
            end
            if (t == FRAME) check($sformatf("tbl%0d_frame_done", v), 32'(frame_done), 32'd1);
         end
      end

      // Snapshot: digit change mid-SHOW must not reach seg
      tick(1'b0, 1'b0, 16'h000A);
      repeat (BC + 2) tick(1'b1, 1'b0, 16'h000A);
      check("snap_an", 32'(an), 32'd1);
      check("snap_seg_invalid", 32'(seg), 32'd0);
      repeat (SC - 2) begin
         tick(1'b1, 1'b0, 16'h0008);
         check("snap_seg_hold", 32'(seg), 32'd0);
      end

      // Enable drop during digit 2 SHOW, then restart from digit 0
      tick(1'b0, 1'b0, 16'h1234);
      repeat (2 * SLOT + BC + 2) tick(1'b1, 1'b0, 16'h1234);
      check("drop_pre_an", 32'(an), 32'b0100);
      tick(1'b0, 1'b0, 16'h1234);
      check("drop_seg", 32'(seg), 32'd0);
      check("drop_an", 32'(an), 32'd0);
      repeat (BC) begin
         tick(1'b1, 1'b0, 16'h1234);
         check("restart_dark_an", 32'(an), 32'd0);
      end
      tick(1'b1, 1'b0, 16'h1234);
      check("restart_an", 32'(an), 32'b0001);
      check("restart_seg", 32'(seg), 32'b0110011);

      // Asynchronous reset between edges during SHOW
      tick(1'b0, 1'b0, 16'h5678);
      repeat (SLOT + BC + 2) tick(1'b1, 1'b0, 16'h5678);
      check("areset_pre_an", 32'(an), 32'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_seg", 32'(seg), 32'd0);
      check("areset_an", 32'(an), 32'd0);
      check("areset_frame_done", 32'(frame_done), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the reference model
      rdig = 16'h0000;
      rlz  = 1'b0;
      for (int c = 0; c < 800; c++) begin
         ren = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 7) == 0) begin
            for (int n = 0; n < 4; n++)
               rdig[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         end
         if ($urandom_range(0, 31) == 0) rlz = ~rlz;
         tick(ren, rlz, rdig);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
